mem_port_arbiter: RTL

Sequences the core's single shared memory port between instruction fetch and load/store data accesses. Accepts one request at a time from each requester, arbitrates, drives a variable-latency request/ack memory port, generates byte strobes from the controller's `store_size` encoding, and returns read data or an error pulse. Sits between the fetch stage, the controller's `memory_en`/`store_size` path and the memory.

---
 rtl/mem_port_arbiter.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one request/ack memory port between instruction fetch and data accesses.
// One access is outstanding at a time; every output is driven from a flop.
`default_nettype none

module mem_port_arbiter #(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_valid,
  output logic        if_err,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_store_size,
  output logic        d_valid,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    D_BUSY  = 2'd2,
    RESP    = 2'd3
  } state_e;

  function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   store_strb = 4'b0001 << off;
      2'b01:   store_strb = 4'b0011 << {off[1], 1'b0};
      2'b10:   store_strb = 4'b1111;
      default: store_strb = 4'b0000;
    endcase
  endfunction

  // Store data is replicated across every lane so the strobes alone select bytes.
  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      2'b00:   lane_data = {4{wdata[7:0]}};
      2'b01:   lane_data = {2{wdata[15:0]}};
      2'b10:   lane_data = wdata;
      default: lane_data = 32'h0000_0000;
    endcase
  endfunction

  // Loads are full-word reads, so they share the word alignment rule.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = off[0];
      default: misaligned = (off != 2'b00);
    endcase
  endfunction

  state_e            state_q, state_d;
  logic              last_d_q, last_d_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wstrb_q, mem_wstrb_d;
  logic              if_valid_q, if_valid_d;
  logic              if_err_q, if_err_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic              d_valid_q, d_valid_d;
  logic              d_err_q, d_err_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic              busy_q, busy_d;
  logic              if_addr_unused_s;

  assign if_addr_unused_s = ^if_addr[1:0];

  // Next-state logic: arbitration, request latching, ack/timeout handling.
  always_comb begin
    state_d     = state_q;
    last_d_d    = last_d_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_valid_d  = 1'b0;
    if_err_d    = 1'b0;
    d_valid_d   = 1'b0;
    d_err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        // Data wins a tie unless it won the previous grant.
        if (d_req && (!if_req || !last_d_q)) begin
          last_d_d = 1'b1;
          if (misaligned(d_store_size, d_addr[1:0])) begin
            state_d   = RESP;
            d_valid_d = 1'b1;
            d_err_d   = 1'b1;
            d_rdata_d = 32'h0000_0000;
          end else begin
            state_d     = D_BUSY;
            mem_req_d   = 1'b1;
            mem_we_d    = (d_store_size != 2'b11);
            mem_addr_d  = {d_addr[31:2], 2'b00};
            mem_wstrb_d = store_strb(d_store_size, d_addr[1:0]);
            mem_wdata_d = lane_data(d_store_size, d_wdata);
            cnt_d       = '0;
          end
        end else if (if_req) begin
          last_d_d    = 1'b0;
          state_d     = IF_BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = {if_addr[31:2], 2'b00};
          mem_wstrb_d = 4'b0000;
          mem_wdata_d = 32'h0000_0000;
          cnt_d       = '0;
        end else begin
          state_d = IDLE;
        end
      end

      IF_BUSY, D_BUSY: begin
        // An ack in the last allowed cycle still counts as success.
        if (mem_ack || (cnt_q == CNT_LAST)) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (state_q == D_BUSY) begin
            d_valid_d = 1'b1;
            d_err_d   = !mem_ack;
            d_rdata_d = mem_ack ? mem_rdata : 32'h0000_0000;
          end else begin
            if_valid_d = 1'b1;
            if_err_d   = !mem_ack;
            if_rdata_d = mem_ack ? mem_rdata : 32'h0000_0000;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      last_d_q    <= 1'b0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0000_0000;
      mem_wdata_q <= 32'h0000_0000;
      mem_wstrb_q <= 4'b0000;
      if_valid_q  <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= 32'h0000_0000;
      d_valid_q   <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= 32'h0000_0000;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_d_q    <= last_d_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      if_valid_q  <= if_valid_d;
      if_err_q    <= if_err_d;
      if_rdata_q  <= if_rdata_d;
      d_valid_q   <= d_valid_d;
      d_err_q     <= d_err_d;
      d_rdata_q   <= d_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign if_valid  = if_valid_q;
  assign if_err    = if_err_q;
  assign if_rdata  = if_rdata_q;
  assign d_valid   = d_valid_q;
  assign d_err     = d_err_q;
  assign d_rdata   = d_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign busy      = busy_q;

endmodule

`default_nettype wire
